// File: rtl/imm_ext_pipe_pkg.sv
// Shared control encodings for the immediate-extension pipeline.
//   ExtOpW     : width of the extend-mode field
//   EXT_*      : extend-mode encodings carried on in_op
//   FIFO_DEPTH : number of entries held by the skid buffer
package imm_ext_pipe_pkg;

  localparam int unsigned ExtOpW = 3;
  typedef logic [ExtOpW-1:0] ext_op_t;

  localparam ext_op_t EXT_ZERO    = 3'd0;
  localparam ext_op_t EXT_SIGNED  = 3'd1;
  localparam ext_op_t EXT_HIGHPOS = 3'd2;
  localparam ext_op_t EXT_BRANCH  = 3'd3;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  // Encodings above EXT_BRANCH are reserved and flagged as errors.
  function automatic logic op_is_legal(ext_op_t op);
    return op <= EXT_BRANCH;
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Stream interface of the immediate-extension pipeline.
//   in_*  : producer channel (valid/ready, raw immediate, mode, tag)
//   out_* : consumer channel (valid/ready, extended immediate, tag, error)
// Modports:
//   master : the environment side (drives in_* payload and out_ready)
//   slave  : the pipeline side (drives in_ready and out_* payload)
interface imm_ext_pipe_if
  import imm_ext_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  ext_op_t          in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
//   imm   : raw IN_W-bit immediate
//   op    : extend mode (EXT_ZERO/SIGNED/HIGHPOS/BRANCH; others illegal)
//   value : OUT_W-bit extended result, 0 for an illegal mode
//   err   : 1 when op is not a legal mode
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_op_t          op,
  output logic [OUT_W-1:0] value,
  output logic             err
);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_core: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_high;
  logic [OUT_W-1:0] w_branch;

  assign w_zext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign w_sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign w_high   = {imm, {(OUT_W-IN_W){1'b0}}};
  // The two bits shifted out are sign copies, so no information is lost.
  assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

  always_comb begin
    value = '0;
    err   = !op_is_legal(op);
    case (op)
      EXT_ZERO:    value = w_zext;
      EXT_SIGNED:  value = w_sext;
      EXT_HIGHPOS: value = w_high;
      EXT_BRANCH:  value = w_branch;
      default:     value = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipeline: extends each accepted immediate at push time and
// holds the result in a 2-entry skid FIFO.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset, overrides flush/push/pop
//   flush : discard all buffered entries next cycle (wins over push/pop)
//   bus   : slave modport of imm_ext_pipe_if (in_* producer, out_* consumer)
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  imm_ext_pipe_if.slave bus
);

  logic [1:0]       r_count;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [OUT_W-1:0] r_val [2];
  logic [TAG_W-1:0] r_tag [2];
  logic [1:0]       r_err;

  logic [1:0]       w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic [OUT_W-1:0] w_ext_val;
  logic             w_ext_err;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm  (bus.in_imm),
    .op   (bus.in_op),
    .value(w_ext_val),
    .err  (w_ext_err)
  );

  // Ready depends on stored occupancy only, never on out_ready.
  assign bus.in_ready  = (r_count != FIFO_DEPTH);
  assign bus.out_valid = (r_count != 2'd0);

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Payload storage is not reset; a write discarded by flush/reset is never
  // visible because the count does not cover it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_val[r_wr_ptr] <= w_ext_val;
      r_tag[r_wr_ptr] <= bus.in_tag;
      r_err[r_wr_ptr] <= w_ext_err;
    end
  end

  // Outputs are forced to zero while empty so stale payload never leaks.
  always_comb begin
    bus.out_imm = '0;
    bus.out_tag = '0;
    bus.out_err = 1'b0;
    if (r_count != 2'd0) begin
      bus.out_imm = r_val[r_rd_ptr];
      bus.out_tag = r_tag[r_rd_ptr];
      bus.out_err = r_err[r_rd_ptr];
    end
  end

endmodule
